line_fill_ctrl: RTL and testbench
=================================

LINE_FILL_CTRL -- requirements
Module: line_fill_ctrl

Interface
REQ-001 SHALL have parameter BURST_AMOUNT, default 8, meaning words per line fill (power of two, 1..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 8'd64, meaning the watchdog limit in cycles (used only with LINE_FILL_TIMEOUT_EN).
REQ-003 SHALL have port clk  in  1  meaning the single clock (rising edge).
REQ-004 SHALL have port rst  in  1  meaning reset; one clock; reset is asynchronous and active-low (rst=0 resets).
REQ-005 SHALL have ports cpu_rd, cpu_wr  in  1  meaning CPU load-miss fill request and store request.
REQ-006 SHALL have ports cpu_addr, cpu_wr_data  in  32  meaning the byte address and the store word.
REQ-007 SHALL have ports cpu_busy, cpu_done, cpu_err  out  1  meaning freeze, one-cycle completion pulse, and timeout flag.
REQ-008 SHALL have port cpu_rd_data  out  32  meaning the requested word of the filled line.
REQ-009 SHALL have ports mem_rd, mem_wr  out  1; mem_addr, mem_wr_data  out  32  meaning the memory request.
REQ-010 SHALL have ports mem_ready, mem_rd_data_valid  in  1; mem_rd_data  in  32  meaning the memory response.
REQ-011 SHALL have ports fill_we  out  1; fill_idx  out  4; fill_data  out  32  meaning the per-beat write port into the cache data array.

Function
REQ-012 SHALL implement states IDLE, REQ, WAIT_RD, WAIT_WR, DONE.
REQ-013 In IDLE: if cpu_wr, capture addr/data and go to REQ with op=write; else if cpu_rd, go to REQ with op=read; write has priority when both are high.
REQ-014 In REQ: assert mem_rd or mem_wr per op; move to WAIT_RD/WAIT_WR in the first cycle where mem_ready=1 (acceptance); hold otherwise.
REQ-015 mem_rd and mem_wr SHALL be high only in REQ and never both.
REQ-016 mem_addr SHALL be stable from REQ through DONE: read = {addr[31:OFF], OFF'b0} with OFF=log2(4*BURST_AMOUNT); write = {addr[31:2], 2'b0}.
REQ-017 mem_wr_data SHALL equal the captured cpu_wr_data while op=write, and 0 otherwise.
REQ-018 WAIT_RD: on each mem_rd_data_valid, fill_we=1 same cycle, fill_idx=beat count, fill_data=mem_rd_data; the beat count increments.
REQ-019 When beat fill_idx equals addr word offset, cpu_rd_data SHALL register mem_rd_data.
REQ-020 The beat with count BURST_AMOUNT-1 SHALL move to DONE; the count wraps to 0.
REQ-021 WAIT_WR: the first cycle with mem_ready=1 SHALL move to DONE.
REQ-022 DONE SHALL last exactly one cycle with cpu_done=1, then go to IDLE.
REQ-023 cpu_busy SHALL be 1 in every state except IDLE; CPU requests outside IDLE are ignored (the CPU holds them).
REQ-024 mem_rd_data_valid outside WAIT_RD SHALL be ignored (fill_we stays 0).
REQ-025 Read latency SHALL be cpu_done exactly one cycle after the last beat.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE, clear the beat count and timer, and drive all outputs to 0, including mid-burst; mem_rd/mem_wr drop immediately.
REQ-027 After rst release, the first request SHALL be accepted on the first rising edge.

Configuration
REQ-028 With macro LINE_FILL_TIMEOUT_EN defined, a timer SHALL clear on REQ entry and on each beat and count in REQ/WAIT_RD/WAIT_WR.
REQ-029 When the timer reaches TIMEOUT_CYCLES, the block SHALL go to DONE with cpu_err=1 for that cycle and discard the remaining beats.
REQ-030 Without the macro, there SHALL be no timer, cpu_err SHALL be tied 0, and waits are unbounded.

Structure
REQ-031 Shared package mem_if_pkg SHALL hold the state encoding, the op encoding (read/write) and the default BURST_AMOUNT/TIMEOUT_CYCLES constants.
REQ-032 The timeout timer SHALL be a sub-module line_fill_timer, instantiated only under LINE_FILL_TIMEOUT_EN.

Verification
REQ-033 Read fill: cpu_rd, addr=0x44, mem_ready 1, 8 beats 0x13000000+i -> 8 fill_we pulses with idx 0..7, mem_addr=0x40, cpu_rd_data=0x13000001, cpu_done one cycle after beat 7.
REQ-034 Store: cpu_wr, addr=0x0, data=0x20, mem_ready low 16 cycles -> mem_wr held with mem_addr=0x0, mem_wr_data=0x20; cpu_done the cycle after mem_ready returns high.
REQ-035 cpu_rd and cpu_wr both high -> a write is issued and mem_rd stays 0.
REQ-036 rst=0 after beat 3 of a fill -> outputs 0 asynchronously; a new read afterwards restarts at fill_idx 0.
REQ-037 With LINE_FILL_TIMEOUT_EN, no beats after acceptance -> cpu_done and cpu_err pulse 64 cycles later, then IDLE.
REQ-038 A stray mem_rd_data_valid in IDLE -> no fill_we and cpu_busy stays 0.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared types and defaults for the line-fill controller: FSM state and
// memory-op encodings, default burst length and watchdog limit.
package mem_if_pkg;

  localparam int unsigned DefBurstAmount   = 8;
  localparam logic [7:0]  DefTimeoutCycles = 8'd64;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitRd,
    StWaitWr,
    StDone
  } state_e;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } op_e;

  // Byte address of the first word of the line holding addr.
  function automatic logic [31:0] line_base(input logic [31:0] addr, input int unsigned burst);
    line_base = addr & ~(32'(4 * burst) - 32'd1);
  endfunction

endpackage

// File: rtl/line_fill_ctrl_if.sv
// CPU, memory and fill-port signals of the line-fill controller.
// master = the controller, slave = the CPU/memory/data-array side.
interface line_fill_ctrl_if;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wr_data;
  logic        cpu_busy;
  logic        cpu_done;
  logic        cpu_err;
  logic [31:0] cpu_rd_data;

  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_ready;
  logic        mem_rd_data_valid;
  logic [31:0] mem_rd_data;

  logic        fill_we;
  logic [3:0]  fill_idx;
  logic [31:0] fill_data;

  modport master (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wr_data,
    input  mem_ready, mem_rd_data_valid, mem_rd_data,
    output cpu_busy, cpu_done, cpu_err, cpu_rd_data,
    output mem_rd, mem_wr, mem_addr, mem_wr_data,
    output fill_we, fill_idx, fill_data
  );

  modport slave (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wr_data,
    output mem_ready, mem_rd_data_valid, mem_rd_data,
    input  cpu_busy, cpu_done, cpu_err, cpu_rd_data,
    input  mem_rd, mem_wr, mem_addr, mem_wr_data,
    input  fill_we, fill_idx, fill_data
  );
endinterface

// File: rtl/line_fill_timer.sv
// Watchdog for the line-fill controller: counts while enabled, clears on
// clr_i, and flags the cycle in which the count would reach TIMEOUT_CYCLES.
module line_fill_timer
  import mem_if_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'd0;
    end else if (en_i) begin
      count_d = count_q + 8'd1;
    end
  end

  assign expired_o = en_i && !clr_i && ((count_q + 8'd1) == TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/line_fill_ctrl.sv
// Cache line-fill / store controller. Optional watchdog built in when
// LINE_FILL_TIMEOUT_EN is defined; otherwise waits are unbounded and cpu_err is 0.
module line_fill_ctrl
  import mem_if_pkg::*;
#(
  parameter int unsigned BURST_AMOUNT   = DefBurstAmount,
  parameter logic [7:0]  TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input logic             clk,
  input logic             rst,
  line_fill_ctrl_if.master bus
);

  localparam logic [3:0] LastBeat = 4'(BURST_AMOUNT - 1);
  localparam logic [3:0] WordMask = 4'(BURST_AMOUNT - 1);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  off_q, off_d;
  logic [3:0]  beat_q, beat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        timeout;

`ifdef LINE_FILL_TIMEOUT_EN
  logic tmr_en, tmr_clr;

  assign tmr_en  = (state_q == StReq) || (state_q == StWaitRd) || (state_q == StWaitWr);
  // Each accepted beat restarts the watchdog.
  assign tmr_clr = !tmr_en || ((state_q == StWaitRd) && bus.mem_rd_data_valid);

  line_fill_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expired_o(timeout)
  );
`else
  // No watchdog: the limit is irrelevant and the timeout never fires.
  assign timeout = (TIMEOUT_CYCLES == 8'd0) && 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    beat_d  = beat_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.cpu_wr) begin
          state_d = StReq;
          op_d    = OpWrite;
          addr_d  = {bus.cpu_addr[31:2], 2'b00};
          wdata_d = bus.cpu_wr_data;
        end else if (bus.cpu_rd) begin
          state_d = StReq;
          op_d    = OpRead;
          addr_d  = line_base(bus.cpu_addr, BURST_AMOUNT);
          wdata_d = 32'd0;
          off_d   = bus.cpu_addr[5:2] & WordMask;
        end
      end
      StReq: begin
        if (bus.mem_ready) begin
          state_d = (op_q == OpWrite) ? StWaitWr : StWaitRd;
        end else if (timeout) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      StWaitRd: begin
        if (bus.mem_rd_data_valid) begin
          beat_d = beat_q + 4'd1;
          if (beat_q == off_q) begin
            rdata_d = bus.mem_rd_data;
          end
          if (beat_q == LastBeat) begin
            beat_d  = 4'd0;
            state_d = StDone;
          end
        end else if (timeout) begin
          // Abandon the burst; later beats arrive outside WAIT_RD and are dropped.
          beat_d  = 4'd0;
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      StWaitWr: begin
        if (bus.mem_ready) begin
          state_d = StDone;
        end else if (timeout) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      op_q    <= OpRead;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      off_q   <= 4'd0;
      beat_q  <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      beat_q  <= beat_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.cpu_busy    = (state_q != StIdle);
  assign bus.cpu_done    = (state_q == StDone);
  assign bus.cpu_err     = err_q;
  assign bus.cpu_rd_data = rdata_q;

  assign bus.mem_rd      = (state_q == StReq) && (op_q == OpRead);
  assign bus.mem_wr      = (state_q == StReq) && (op_q == OpWrite);
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_data = wdata_q;

  assign bus.fill_we     = (state_q == StWaitRd) && bus.mem_rd_data_valid;
  assign bus.fill_idx    = beat_q;
  assign bus.fill_data   = bus.fill_we ? bus.mem_rd_data : 32'd0;

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Bench for line_fill_ctrl: directed transactions with a per-cycle expected
// schedule, plus literal checks. Watchdog scenario runs when LINE_FILL_TIMEOUT_EN is defined.
module tb_line_fill_ctrl;

  localparam int unsigned BA = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  line_fill_ctrl_if bus ();

  line_fill_ctrl #(
    .BURST_AMOUNT  (BA),
    .TIMEOUT_CYCLES(8'd64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected outputs for the current cycle.
  logic        chk_en = 1'b0;
  logic        e_busy, e_done, e_err, e_mrd, e_mwr, e_fwe, e_bus;
  logic [31:0] e_maddr, e_mwdata, e_fdata, e_rdata, m_rdata;
  logic [3:0]  e_fidx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cpu_busy", 32'(bus.cpu_busy), 32'(e_busy));
      chk("cpu_done", 32'(bus.cpu_done), 32'(e_done));
      chk("cpu_err", 32'(bus.cpu_err), 32'(e_err));
      chk("mem_rd", 32'(bus.mem_rd), 32'(e_mrd));
      chk("mem_wr", 32'(bus.mem_wr), 32'(e_mwr));
      chk("fill_we", 32'(bus.fill_we), 32'(e_fwe));
      chk("cpu_rd_data", bus.cpu_rd_data, e_rdata);
      if (e_bus) begin
        chk("mem_addr", bus.mem_addr, e_maddr);
        chk("mem_wr_data", bus.mem_wr_data, e_mwdata);
      end
      if (e_fwe) begin
        chk("fill_idx", 32'(bus.fill_idx), 32'(e_fidx));
        chk("fill_data", bus.fill_data, e_fdata);
      end
    end
  end

  // Event monitor feeding the literal checks.
  int cyc_n = 0, pulses = 0, idx_sum = 0, last_beat_at = 0, done_at = 0, acc_at = 0;
  int mwr_cycles = 0, mrd_cycles = 0, err_pulses = 0;
  logic [31:0] rd_addr_seen = 32'd0, wr_addr_seen = 32'd0, wr_data_seen = 32'd0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (bus.fill_we) begin
      pulses  = pulses + 1;
      idx_sum = idx_sum + int'(bus.fill_idx);
      if (bus.fill_idx == 4'(BA - 1)) last_beat_at = cyc_n;
    end
    if (bus.cpu_done) done_at = cyc_n;
    if (bus.cpu_err) err_pulses = err_pulses + 1;
    if (bus.mem_rd) begin
      mrd_cycles   = mrd_cycles + 1;
      rd_addr_seen = bus.mem_addr;
      if (bus.mem_ready) acc_at = cyc_n;
    end
    if (bus.mem_wr) begin
      mwr_cycles   = mwr_cycles + 1;
      wr_addr_seen = bus.mem_addr;
      wr_data_seen = bus.mem_wr_data;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "bench timeout");
  end

  // Advance to just after the next rising edge; default to a busy cycle.
  task automatic next();
    @(posedge clk);
    #1;
    e_rdata = m_rdata;
    e_busy  = 1'b1;
    e_done  = 1'b0;
    e_err   = 1'b0;
    e_mrd   = 1'b0;
    e_mwr   = 1'b0;
    e_fwe   = 1'b0;
    e_bus   = 1'b1;
  endtask

  task automatic exp_idle();
    e_busy = 1'b0;
    e_bus  = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " cpu_busy"}, 32'(bus.cpu_busy), 32'd0);
    chk({tag, " cpu_done"}, 32'(bus.cpu_done), 32'd0);
    chk({tag, " cpu_err"}, 32'(bus.cpu_err), 32'd0);
    chk({tag, " cpu_rd_data"}, bus.cpu_rd_data, 32'd0);
    chk({tag, " mem_rd"}, 32'(bus.mem_rd), 32'd0);
    chk({tag, " mem_wr"}, 32'(bus.mem_wr), 32'd0);
    chk({tag, " mem_addr"}, bus.mem_addr, 32'd0);
    chk({tag, " mem_wr_data"}, bus.mem_wr_data, 32'd0);
    chk({tag, " fill_we"}, 32'(bus.fill_we), 32'd0);
    chk({tag, " fill_idx"}, 32'(bus.fill_idx), 32'd0);
    chk({tag, " fill_data"}, bus.fill_data, 32'd0);
  endtask

  // Line fill: acc stall cycles in REQ, optional idle gaps between beats.
  // pre=1 means the request is already on the bus before the first edge.
  task automatic read_fill(input logic [31:0] addr, input int acc, input bit gaps,
                           input logic [31:0] base, input bit pre);
    int off;
    off = int'((addr % (4 * BA)) / 4);
    if (!pre) begin
      next();
      exp_idle();
      bus.cpu_rd    = 1'b1;
      bus.cpu_addr  = addr;
      bus.mem_ready = 1'b0;
    end
    e_maddr  = (addr / (4 * BA)) * (4 * BA);
    e_mwdata = 32'd0;
    for (int d = 0; d <= acc; d++) begin
      next();
      e_mrd = 1'b1;
      bus.mem_ready = (d == acc);
    end
    for (int i = 0; i < BA; i++) begin
      if (gaps && (i % 3 == 1)) begin
        next();
        bus.mem_ready = 1'b0;
        bus.mem_rd_data_valid = 1'b0;
      end
      next();
      bus.mem_ready = 1'b0;
      bus.mem_rd_data_valid = 1'b1;
      bus.mem_rd_data = base + 32'(i);
      e_fwe   = 1'b1;
      e_fidx  = 4'(i);
      e_fdata = base + 32'(i);
      if (i == off) m_rdata = base + 32'(i);
    end
    next();
    bus.mem_rd_data_valid = 1'b0;
    bus.cpu_rd = 1'b0;
    e_done = 1'b1;
    next();
    exp_idle();
  endtask

  // Store: acc stall cycles in REQ, wwait stall cycles in WAIT_WR; stray beats during REQ.
  task automatic write_store(input logic [31:0] addr, input logic [31:0] data, input int acc,
                             input int wwait, input bit both);
    next();
    exp_idle();
    bus.cpu_wr      = 1'b1;
    bus.cpu_rd      = both;
    bus.cpu_addr    = addr;
    bus.cpu_wr_data = data;
    bus.mem_ready   = 1'b0;
    e_maddr  = (addr / 4) * 4;
    e_mwdata = data;
    for (int d = 0; d <= acc; d++) begin
      next();
      e_mwr = 1'b1;
      bus.mem_ready = (d == acc);
      bus.mem_rd_data_valid = 1'b1;
      bus.mem_rd_data = 32'hBAD00000 + 32'(d);
    end
    for (int w = 0; w <= wwait; w++) begin
      next();
      bus.mem_rd_data_valid = 1'b0;
      bus.mem_ready = (w == wwait);
    end
    next();
    bus.mem_ready = 1'b0;
    bus.cpu_wr = 1'b0;
    bus.cpu_rd = 1'b0;
    e_done = 1'b1;
    next();
    exp_idle();
  endtask

  int p0, s0, r0;

  initial begin
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
    bus.cpu_addr = 32'd0;
    bus.cpu_wr_data = 32'd0;
    bus.mem_ready = 1'b0;
    bus.mem_rd_data_valid = 1'b1;
    bus.mem_rd_data = 32'hDEADBEEF;
    m_rdata = 32'd0;
    e_rdata = 32'd0;

    #1 rst = 1'b0;
    #1 check_zero("por");
    #21 rst = 1'b1;
    bus.mem_rd_data_valid = 1'b0;

    // Stray beats in IDLE must not write the array or raise busy.
    for (int k = 0; k < 3; k++) begin
      next();
      exp_idle();
      chk_en = 1'b1;
      bus.mem_rd_data_valid = 1'b1;
      bus.mem_rd_data = 32'h5A5A0000 + 32'(k);
    end
    p0 = pulses;
    next();
    exp_idle();
    bus.mem_rd_data_valid = 1'b0;
    chk("stray_fill_we", 32'(pulses - p0), 32'd0);

    p0 = pulses;
    s0 = idx_sum;
    read_fill(32'h44, 0, 1'b0, 32'h13000000, 1'b0);
    chk("lit_pulses", 32'(pulses - p0), 32'd8);
    chk("lit_idx_sum", 32'(idx_sum - s0), 32'd28);
    chk("lit_rd_addr", rd_addr_seen, 32'h40);
    chk("lit_rd_data", bus.cpu_rd_data, 32'h13000001);
    chk("lit_done_lat", 32'(done_at - last_beat_at), 32'd1);

    r0 = mwr_cycles;
    write_store(32'h0, 32'h20, 16, 0, 1'b0);
    chk("lit_wr_cycles", 32'(mwr_cycles - r0), 32'd17);
    chk("lit_wr_addr", wr_addr_seen, 32'h0);
    chk("lit_wr_data", wr_data_seen, 32'h20);

    r0 = mrd_cycles;
    write_store(32'h1236, 32'hCAFEF00D, 2, 3, 1'b1);
    chk("lit_both_no_rd", 32'(mrd_cycles - r0), 32'd0);
    chk("lit_both_addr", wr_addr_seen, 32'h1234);

    read_fill(32'h7C, 2, 1'b1, 32'hA5000000, 1'b0);
    chk("lit_rd_data_last", bus.cpu_rd_data, 32'hA5000007);
    read_fill(32'h100, 0, 1'b1, 32'h00BEEF00, 1'b0);
    chk("lit_rd_data_first", bus.cpu_rd_data, 32'h00BEEF00);

    // Reset after beat 3 of a fill, then an immediately accepted new read.
    next();
    exp_idle();
    bus.cpu_rd = 1'b1;
    bus.cpu_addr = 32'h2C;
    next();
    e_mrd = 1'b1;
    e_maddr = 32'h20;
    e_mwdata = 32'd0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next();
      bus.mem_ready = 1'b0;
      bus.mem_rd_data_valid = 1'b1;
      bus.mem_rd_data = 32'h77000000 + 32'(i);
      e_fwe = 1'b1;
      e_fidx = 4'(i);
      e_fdata = 32'h77000000 + 32'(i);
      if (i == 3) m_rdata = 32'h77000003;
    end
    next();
    bus.mem_rd_data_valid = 1'b0;
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    rst = 1'b0;
    bus.mem_rd_data_valid = 1'b1;
    #1 check_zero("rst_mid");
    bus.mem_rd_data_valid = 1'b0;
    bus.cpu_rd = 1'b1;
    bus.cpu_addr = 32'h08;
    #10 check_zero("rst_hold");
    #1 rst = 1'b1;
    m_rdata = 32'd0;
    chk_en = 1'b1;
    p0 = pulses;
    s0 = idx_sum;
    read_fill(32'h08, 0, 1'b0, 32'h31000000, 1'b1);
    chk("lit_restart_pulses", 32'(pulses - p0), 32'd8);
    chk("lit_restart_idx_sum", 32'(idx_sum - s0), 32'd28);
    chk("lit_restart_rd_data", bus.cpu_rd_data, 32'h31000002);

    // Reset while a store is being requested: mem_wr must drop at once.
    next();
    exp_idle();
    bus.cpu_wr = 1'b1;
    bus.cpu_addr = 32'h50;
    bus.cpu_wr_data = 32'h99;
    next();
    e_mwr = 1'b1;
    e_maddr = 32'h50;
    e_mwdata = 32'h99;
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    rst = 1'b0;
    #1 check_zero("rst_wr");
    bus.cpu_wr = 1'b0;
    #1 rst = 1'b1;
    m_rdata = 32'd0;
    next();
    exp_idle();
    chk_en = 1'b1;

`ifdef LINE_FILL_TIMEOUT_EN
    // Accepted read with no beats: watchdog ends it 64 cycles after acceptance.
    r0 = err_pulses;
    next();
    exp_idle();
    bus.cpu_rd = 1'b1;
    bus.cpu_addr = 32'h80;
    next();
    e_mrd = 1'b1;
    e_maddr = 32'h80;
    e_mwdata = 32'd0;
    bus.mem_ready = 1'b1;
    for (int k = 1; k < 64; k++) begin
      next();
      bus.mem_ready = 1'b0;
    end
    next();
    e_done = 1'b1;
    e_err = 1'b1;
    bus.cpu_rd = 1'b0;
    next();
    exp_idle();
    chk("lit_tmo_lat", 32'(done_at - acc_at), 32'd64);
    chk("lit_tmo_err_pulses", 32'(err_pulses - r0), 32'd1);
    read_fill(32'h84, 0, 1'b0, 32'h42000000, 1'b0);
    chk("lit_tmo_after_rd_data", bus.cpu_rd_data, 32'h42000001);
`endif

    next();
    exp_idle();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
